// File: rtl/voxel_pkg.sv
// Shared constants, pixel types and grayscale helpers for the
// TLC5955 slice buffer.
package voxel_pkg;

    localparam int NUM_LANES     = 48;
    localparam int LEDS_PER_LANE = 32;
    localparam int GS_BITS       = 48;

    localparam int R_OFS = 0;
    localparam int G_OFS = 16;
    localparam int B_OFS = 32;

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int LED_W  = $clog2(LEDS_PER_LANE);
    localparam int BIT_W  = $clog2(GS_BITS);
    localparam int ROW_W  = NUM_LANES * 24;

    typedef logic [23:0] rgb_t;
    typedef logic [NUM_LANES-1:0][23:0] row_t;

    function automatic logic [15:0] gs_expand(logic [7:0] c);
        return {c, c};
    endfunction

    // Bit b of the 48-bit {B16,G16,R16} word of one pixel.
    function automatic logic gs_bit(rgb_t px, logic [BIT_W-1:0] b);
        logic [GS_BITS-1:0] w;
        w = '0;
        w[R_OFS +: 16] = gs_expand(px[23:16]);
        w[G_OFS +: 16] = gs_expand(px[15:8]);
        w[B_OFS +: 16] = gs_expand(px[7:0]);
        return (b < BIT_W'(GS_BITS)) ? w[b] : 1'b0;
    endfunction

endpackage

// File: rtl/slice_gs_buffer_if.sv
// Pixel stream, swap and grayscale read bundle between the
// slice producer / shifter (master) and the slice buffer (slave).
interface slice_gs_buffer_if;
    import voxel_pkg::*;

    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_sof;
    rgb_t                 pix_rgb;
    logic                 swap_req;
    logic                 rd_en;
    logic [LED_W-1:0]     rd_led;
    logic [BIT_W-1:0]     rd_bit;
    logic [NUM_LANES-1:0] gs_bits;
    logic                 gs_valid;
    logic                 slice_valid;
    logic                 wr_full;
    logic [15:0]          underrun_cnt;

    modport master (
        output pix_valid, pix_sof, pix_rgb, swap_req,
        output rd_en, rd_led, rd_bit,
        input  pix_ready, gs_bits, gs_valid,
        input  slice_valid, wr_full, underrun_cnt
    );

    modport slave (
        input  pix_valid, pix_sof, pix_rgb, swap_req,
        input  rd_en, rd_led, rd_bit,
        output pix_ready, gs_bits, gs_valid,
        output slice_valid, wr_full, underrun_cnt
    );

endinterface

// File: rtl/slice_ram.sv
// Two-bank simple dual-port row RAM with registered read.
// Bank select is the address MSB.
module slice_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 1152,
    parameter int AW    = 6
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/slice_gs_buffer.sv
// Ping-pong voxel slice buffer feeding the TLC5955 grayscale shifter:
// fills one bank row-by-row while the shifter reads the other bit-parallel.
module slice_gs_buffer
    import voxel_pkg::*;
(
    input  logic         TESTCLK,
    input  logic         nReset,
    slice_gs_buffer_if.slave bus
);

    localparam int AW = LED_W + 1;

    row_t                 stage_q;
    row_t                 row_d;
    logic [LANE_W-1:0]    lane_ptr_q, lane_ptr_d, lane_eff;
    logic [LED_W-1:0]     led_ptr_q, led_ptr_d, led_eff;
    logic                 wr_full_q, wr_full_d;
    logic                 slice_valid_q, slice_valid_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [15:0]          underrun_q, underrun_d;
    logic                 accept, commit, last_lane, last_led;

    logic                 rd_ok;
    logic                 rd_v1_q, rd_ok1_q;
    logic [BIT_W-1:0]     rd_bit1_q;
    logic [ROW_W-1:0]     rd_word;
    logic [NUM_LANES-1:0] gs_bits_q, gs_bits_d;
    logic                 gs_valid_q;

    // A start-of-frame pixel always lands at p=0, dropping any partial slice.
    assign accept    = bus.pix_valid && !wr_full_q;
    assign lane_eff  = bus.pix_sof ? '0 : lane_ptr_q;
    assign led_eff   = bus.pix_sof ? '0 : led_ptr_q;
    assign last_lane = lane_eff == LANE_W'(NUM_LANES - 1);
    assign last_led  = led_eff == LED_W'(LEDS_PER_LANE - 1);
    assign commit    = accept && last_lane;

    always_comb begin
        row_d           = stage_q;
        row_d[lane_eff] = bus.pix_rgb;
    end

    always_comb begin
        lane_ptr_d    = lane_ptr_q;
        led_ptr_d     = led_ptr_q;
        wr_full_d     = wr_full_q;
        wr_bank_d     = wr_bank_q;
        slice_valid_d = slice_valid_q;
        underrun_d    = underrun_q;
        if (accept) begin
            if (last_lane) begin
                lane_ptr_d = '0;
                if (last_led) begin
                    led_ptr_d = '0;
                    wr_full_d = 1'b1;
                end else begin
                    led_ptr_d = led_eff + LED_W'(1);
                end
            end else begin
                lane_ptr_d = lane_eff + LANE_W'(1);
                led_ptr_d  = led_eff;
            end
        end
        // Swap is judged on the registered full flag, so a swap in the
        // same cycle as the final pixel is an underrun.
        if (bus.swap_req) begin
            if (wr_full_q) begin
                wr_bank_d     = !wr_bank_q;
                wr_full_d     = 1'b0;
                slice_valid_d = 1'b1;
            end else if (underrun_q != '1) begin
                underrun_d = underrun_q + 16'd1;
            end
        end
    end

    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            lane_ptr_q    <= '0;
            led_ptr_q     <= '0;
            wr_full_q     <= 1'b0;
            wr_bank_q     <= 1'b0;
            slice_valid_q <= 1'b0;
            underrun_q    <= '0;
        end else begin
            lane_ptr_q    <= lane_ptr_d;
            led_ptr_q     <= led_ptr_d;
            wr_full_q     <= wr_full_d;
            wr_bank_q     <= wr_bank_d;
            slice_valid_q <= slice_valid_d;
            underrun_q    <= underrun_d;
        end
    end

    always_ff @(posedge TESTCLK) begin
        if (accept) begin
            stage_q <= row_d;
        end
    end

    slice_ram #(
        .DEPTH (2 * LEDS_PER_LANE),
        .WIDTH (ROW_W),
        .AW    (AW)
    ) u_ram (
        .clk_i   (TESTCLK),
        .we_i    (commit),
        .waddr_i ({wr_bank_q, led_eff}),
        .wdata_i (row_d),
        .re_i    (bus.rd_en),
        .raddr_i ({!wr_bank_q, bus.rd_led}),
        .rdata_o (rd_word)
    );

    assign rd_ok = slice_valid_q
                && ({1'b0, bus.rd_led} < AW'(LEDS_PER_LANE))
                && (bus.rd_bit < BIT_W'(GS_BITS));

    always_comb begin
        gs_bits_d = gs_bits_q;
        if (rd_v1_q) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                gs_bits_d[l] = rd_ok1_q && gs_bit(rd_word[l*24 +: 24], rd_bit1_q);
            end
        end
    end

    always_ff @(posedge TESTCLK) begin
        if (!nReset) begin
            rd_v1_q    <= 1'b0;
            rd_ok1_q   <= 1'b0;
            rd_bit1_q  <= '0;
            gs_bits_q  <= '0;
            gs_valid_q <= 1'b0;
        end else begin
            rd_v1_q    <= bus.rd_en;
            rd_ok1_q   <= rd_ok;
            rd_bit1_q  <= bus.rd_bit;
            gs_bits_q  <= gs_bits_d;
            gs_valid_q <= rd_v1_q;
        end
    end

    assign bus.pix_ready    = !wr_full_q;
    assign bus.wr_full      = wr_full_q;
    assign bus.slice_valid  = slice_valid_q;
    assign bus.underrun_cnt = underrun_q;
    assign bus.gs_bits      = gs_bits_q;
    assign bus.gs_valid     = gs_valid_q;

endmodule

// File: tb/tb_slice_gs_buffer.sv
// Directed bench for slice_gs_buffer with a slice-level reference model
// compared every cycle, plus literal read-back expectations.
module tb_slice_gs_buffer;
    import voxel_pkg::*;

    localparam int NPIX = NUM_LANES * LEDS_PER_LANE;

    logic TESTCLK = 1'b0;
    logic nReset;
    int   nchecks = 0;
    int   nerrors = 0;

    slice_gs_buffer_if bus();

    slice_gs_buffer dut (
        .TESTCLK (TESTCLK),
        .nReset  (nReset),
        .bus     (bus)
    );

    always #5 TESTCLK = ~TESTCLK;

    // Reference model: whole slices as flat pixel arrays.
    logic [23:0] fill_m [NPIX];
    logic [23:0] cur_m  [NPIX];
    int          m_pos;
    bit          m_full;
    bit          m_sv;
    int          m_und;
    bit          e1_v, e2_v;
    logic [47:0] e1_b, e2_b;
    bit          chk_en = 1'b0;

    task automatic cmp(string nm, logic [47:0] act, logic [47:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [47:0] exp_bits(int led, int b);
        logic [47:0] r;
        logic [23:0] px;
        int          c8;
        int          g16;
        r = '0;
        if (m_sv && led < LEDS_PER_LANE && b < GS_BITS) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                px = cur_m[led * NUM_LANES + l];
                if (b < 16)      c8 = int'(px[23:16]);
                else if (b < 32) c8 = int'(px[15:8]);
                else             c8 = int'(px[7:0]);
                g16  = c8 * 257;
                r[l] = ((g16 >> (b % 16)) & 1) == 1;
            end
        end
        return r;
    endfunction

    task automatic model_step();
        bit pre;
        if (!nReset) begin
            m_pos  = 0;
            m_full = 0;
            m_sv   = 0;
            m_und  = 0;
            e1_v   = 0;
            e2_v   = 0;
            e1_b   = '0;
            e2_b   = '0;
            chk_en = 1;
            return;
        end
        e2_v = e1_v;
        e2_b = e1_b;
        e1_v = bus.rd_en;
        e1_b = exp_bits(int'(bus.rd_led), int'(bus.rd_bit));
        pre  = m_full;
        if (bus.swap_req) begin
            if (pre) begin
                cur_m  = fill_m;
                m_full = 0;
                m_sv   = 1;
            end else if (m_und < 65535) begin
                m_und++;
            end
        end
        if (bus.pix_valid && !pre) begin
            if (bus.pix_sof) m_pos = 0;
            fill_m[m_pos] = bus.pix_rgb;
            m_pos++;
            if (m_pos == NPIX) begin
                m_pos  = 0;
                m_full = 1;
            end
        end
    endtask

    always @(negedge TESTCLK) begin
        if (chk_en) begin
            cmp("pix_ready", bus.pix_ready, !m_full);
            cmp("wr_full", bus.wr_full, m_full);
            cmp("slice_valid", bus.slice_valid, m_sv);
            cmp("underrun_cnt", bus.underrun_cnt, m_und);
            cmp("gs_valid", bus.gs_valid, e2_v);
            if (e2_v) cmp("gs_bits", bus.gs_bits, e2_b);
        end
    end

    task automatic clk_step();
        @(posedge TESTCLK);
        model_step();
        @(negedge TESTCLK);
    endtask

    function automatic logic [23:0] pat(int kind, int p);
        logic [10:0] q;
        q = p[10:0];
        case (kind)
            0:       return 24'hFF0000;
            1:       return (p == 149) ? 24'h008000 : 24'h000000;
            2:       return {q[7:0] ^ 8'h5A, q[10:3], ~q[7:0]};
            default: return 24'h000000;
        endcase
    endfunction

    task automatic push(logic [23:0] rgb, bit sof, bit swp);
        bus.pix_valid = 1'b1;
        bus.pix_rgb   = rgb;
        bus.pix_sof   = sof;
        bus.swap_req  = swp;
        clk_step();
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.swap_req  = 1'b0;
    endtask

    task automatic fill(int first, int last, int kind);
        for (int p = first; p <= last; p++) push(pat(kind, p), 1'b0, 1'b0);
    endtask

    task automatic swap();
        bus.swap_req = 1'b1;
        clk_step();
        bus.swap_req = 1'b0;
    endtask

    task automatic read_chk(string nm, int led, int b, logic [47:0] exp);
        bus.rd_en  = 1'b1;
        bus.rd_led = 5'(led);
        bus.rd_bit = 6'(b);
        clk_step();
        bus.rd_en = 1'b0;
        clk_step();
        cmp({nm, "_v"}, bus.gs_valid, 1);
        cmp(nm, bus.gs_bits, exp);
    endtask

    task automatic burst(int n, int seed);
        for (int i = 0; i < n; i++) begin
            bus.rd_en  = 1'b1;
            bus.rd_led = 5'((i * 7 + seed) % 32);
            bus.rd_bit = 6'((i * 11 + seed) % 64);
            clk_step();
        end
        bus.rd_en = 1'b0;
        clk_step();
        clk_step();
    endtask

    task automatic chk_reset_vals(string nm);
        cmp({nm, "_ready"}, bus.pix_ready, 1);
        cmp({nm, "_gs_bits"}, bus.gs_bits, 0);
        cmp({nm, "_gs_valid"}, bus.gs_valid, 0);
        cmp({nm, "_slice_valid"}, bus.slice_valid, 0);
        cmp({nm, "_wr_full"}, bus.wr_full, 0);
        cmp({nm, "_underrun"}, bus.underrun_cnt, 0);
    endtask

    initial begin
        nReset        = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_rgb   = '0;
        bus.swap_req  = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_led    = '0;
        bus.rd_bit    = '0;
        repeat (3) clk_step();
        chk_reset_vals("rst");
        nReset = 1'b1;
        clk_step();

        // Read before any slice: 2-cycle latency, blank data.
        bus.rd_en  = 1'b1;
        bus.rd_led = '0;
        bus.rd_bit = '0;
        clk_step();
        bus.rd_en = 1'b0;
        cmp("lat1_valid", bus.gs_valid, 0);
        clk_step();
        cmp("lat2_valid", bus.gs_valid, 1);
        cmp("empty_bits", bus.gs_bits, 48'h0);

        // Full red slice.
        fill(0, NPIX - 1, 0);
        cmp("red_full", bus.wr_full, 1);
        cmp("red_ready", bus.pix_ready, 0);
        swap();
        cmp("red_sv", bus.slice_valid, 1);
        cmp("red_wrfull", bus.wr_full, 0);
        read_chk("red_b0", 0, 0, 48'hFFFF_FFFF_FFFF);
        read_chk("red_b15", 31, 15, 48'hFFFF_FFFF_FFFF);
        read_chk("red_b16", 0, 16, 48'h0);
        read_chk("red_b48", 5, 48, 48'h0);

        // Single green pixel at led 3 lane 5.
        fill(0, NPIX - 1, 1);
        swap();
        read_chk("g_b31", 3, 31, 48'h20);
        read_chk("g_b23", 3, 23, 48'h20);
        read_chk("g_b15", 3, 15, 48'h0);
        read_chk("g_led2", 2, 31, 48'h0);

        // Underrun after 1000 pixels, then finish and swap.
        fill(0, 999, 2);
        swap();
        cmp("und1", bus.underrun_cnt, 1);
        read_chk("und_old", 3, 31, 48'h20);
        fill(1000, NPIX - 1, 2);
        cmp("und_full", bus.wr_full, 1);
        cmp("und_ready", bus.pix_ready, 0);
        push(24'h123456, 1'b1, 1'b0);
        push(24'h654321, 1'b0, 1'b0);
        cmp("full_hold", bus.wr_full, 1);
        bus.rd_en  = 1'b1;
        bus.rd_led = 5'd3;
        bus.rd_bit = 6'd31;
        bus.swap_req = 1'b1;
        clk_step();
        bus.rd_en    = 1'b0;
        bus.swap_req = 1'b0;
        clk_step();
        cmp("inflight_bits", bus.gs_bits, 48'h20);
        read_chk("a_b0", 0, 0, 48'hAAAA_AAAA_AAAA);
        read_chk("a_b32", 1, 32, 48'h5555_5555_5555);
        burst(40, 3);

        // Start-of-frame restart at p=700.
        fill(0, 699, 2);
        push(24'h0000FF, 1'b1, 1'b0);
        fill(1, NPIX - 2, 3);
        cmp("sof_notfull", bus.wr_full, 0);
        fill(NPIX - 1, NPIX - 1, 3);
        cmp("sof_full", bus.wr_full, 1);
        swap();
        read_chk("sof_b32", 0, 32, 48'h1);
        read_chk("sof_b39", 0, 39, 48'h1);
        read_chk("sof_b0", 0, 0, 48'h0);

        // Final pixel and swap in the same cycle.
        fill(0, NPIX - 2, 2);
        push(pat(2, NPIX - 1), 1'b0, 1'b1);
        cmp("same_und", bus.underrun_cnt, 2);
        cmp("same_full", bus.wr_full, 1);
        read_chk("same_old", 0, 32, 48'h1);
        swap();
        read_chk("same_new", 0, 0, 48'hAAAA_AAAA_AAAA);
        burst(30, 17);

        // Reset in the middle of a slice.
        fill(0, 499, 0);
        bus.rd_en = 1'b1;
        nReset    = 1'b0;
        clk_step();
        bus.rd_en = 1'b0;
        clk_step();
        chk_reset_vals("mid");
        nReset = 1'b1;
        read_chk("mid_blank", 0, 0, 48'h0);
        fill(0, NPIX - 1, 0);
        swap();
        read_chk("fresh_b0", 7, 0, 48'hFFFF_FFFF_FFFF);
        burst(20, 5);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
